bp_resolve_unit: RTL and testbench

Feedback end of the fetch-stage branch prediction interface. Sits in ID and captures each fetched instruction's prediction (taken flag and target). When the branch unit returns the actual outcome, it compares the two and drives the update/redirect bus back to pc_reg. Drives prediction_result, predicted_pc, is_branch_inst, branch_flag and branch_address. Also sequences the pipeline flush after a misprediction and keeps saturating accuracy counters.

---
 rtl/bp_resolve_unit.sv | 166 ++++++++++++++++
 tb/tb_bp_resolve_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_unit.sv
// Resolves captured fetch-stage predictions against EX outcomes and drives
// the update/redirect bus, post-mispredict flush and accuracy counters.
module bp_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_pc_i,
    input  logic             if_pred_taken_i,
    input  logic [31:0]      if_pred_target_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_branch_i,
    input  logic             ex_taken_i,
    input  logic [31:0]      ex_target_i,
    output logic             prediction_result_o,
    output logic [31:0]      predicted_pc_o,
    output logic [31:0]      target_address_o,
    output logic             is_branch_inst_o,
    output logic             branch_flag_o,
    output logic [31:0]      branch_address_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic             orphan_o
);
    typedef enum logic {RUN, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic              pt_q, pt_d;
    logic [31:0]       ptgt_q, ptgt_d;
    logic              res_q, res_d;
    logic [31:0]       ppc_q, ppc_d;
    logic [31:0]       tgt_q, tgt_d;
    logic              isbr_q, isbr_d;
    logic              bflag_q, bflag_d;
    logic [31:0]       baddr_q, baddr_d;
    logic              orphan_q, orphan_d;
    logic [CNT_W-1:0]  br_q, br_d;
    logic [CNT_W-1:0]  miss_q, miss_d;

    logic run;
    logic resolve;
    logic capture;
    logic mispredict;

    assign run     = (state_q == RUN);
    assign resolve = run && !stall_i && ex_valid_i && valid_q;
    assign capture = run && !stall_i && if_valid_i;

    assign mispredict = ex_is_branch_i
        ? ((pt_q != ex_taken_i) ||
           (pt_q && ex_taken_i && (ptgt_q != ex_target_i)))
        : pt_q;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        pt_d     = pt_q;
        ptgt_d   = ptgt_q;
        res_d    = 1'b1;
        isbr_d   = 1'b0;
        bflag_d  = 1'b0;
        ppc_d    = ppc_q;
        tgt_d    = tgt_q;
        baddr_d  = baddr_q;
        orphan_d = orphan_q;
        br_d     = br_q;
        miss_d   = miss_q;
        unique case (state_q)
            RUN: begin
                if (!stall_i) begin
                    if (ex_valid_i && !valid_q) orphan_d = 1'b1;
                    if (capture && valid_q && !ex_valid_i) orphan_d = 1'b1;
                    if (resolve) begin
                        valid_d = 1'b0;
                        res_d   = !mispredict;
                        isbr_d  = ex_is_branch_i;
                        bflag_d = ex_taken_i & ex_is_branch_i;
                        baddr_d = ex_target_i;
                        ppc_d   = pc_q;
                        tgt_d   = ptgt_q;
                        if (ex_is_branch_i && (br_q != '1))
                            br_d = br_q + CNT_W'(1);
                        if (mispredict && (miss_q != '1))
                            miss_d = miss_q + CNT_W'(1);
                    end
                    // Old entry is consumed above before the new one lands.
                    if (capture) begin
                        valid_d = 1'b1;
                        pc_d    = if_pc_i;
                        pt_d    = if_pred_taken_i;
                        ptgt_d  = if_pred_target_i;
                    end
                    if (resolve && mispredict) begin
                        valid_d = 1'b0;
                        state_d = FLUSH;
                        fcnt_d  = 3'(FLUSH_CYCLES);
                    end
                end
            end
            FLUSH: begin
                if (!stall_i) begin
                    if (fcnt_q == 3'd1) state_d = RUN;
                    else fcnt_d = fcnt_q - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            fcnt_q   <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            pt_q     <= 1'b0;
            ptgt_q   <= '0;
            res_q    <= 1'b1;
            ppc_q    <= '0;
            tgt_q    <= '0;
            isbr_q   <= 1'b0;
            bflag_q  <= 1'b0;
            baddr_q  <= '0;
            orphan_q <= 1'b0;
            br_q     <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            pt_q     <= pt_d;
            ptgt_q   <= ptgt_d;
            res_q    <= res_d;
            ppc_q    <= ppc_d;
            tgt_q    <= tgt_d;
            isbr_q   <= isbr_d;
            bflag_q  <= bflag_d;
            baddr_q  <= baddr_d;
            orphan_q <= orphan_d;
            br_q     <= br_d;
            miss_q   <= miss_d;
        end
    end

    assign prediction_result_o = res_q;
    assign predicted_pc_o      = ppc_q;
    assign target_address_o    = tgt_q;
    assign is_branch_inst_o    = isbr_q;
    assign branch_flag_o       = bflag_q;
    assign branch_address_o    = baddr_q;
    assign flush_o             = (state_q == FLUSH);
    assign busy_o              = valid_q;
    assign br_cnt_o            = br_q;
    assign miss_cnt_o          = miss_q;
    assign orphan_o            = orphan_q;
endmodule

// File: tb/tb_bp_resolve_unit.sv
// Bench for bp_resolve_unit: directed vector table, corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_bp_resolve_unit;
    localparam int FC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, ifv, ifpt, exv, exb, ext;
    logic [31:0] ifpc, ifptg, extg;

    logic        res_o, isbr_o, bf_o, flush_o, busy_o, orph_o;
    logic [31:0] ppc_o, tgt_o, baddr_o, br_o, miss_o;

    logic        s_res, s_isbr, s_bf, s_flush, s_busy, s_orph;
    logic [31:0] s_ppc, s_tgt, s_baddr;
    logic [2:0]  s_br, s_miss;

    bp_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall),
        .if_valid_i(ifv), .if_pc_i(ifpc),
        .if_pred_taken_i(ifpt), .if_pred_target_i(ifptg),
        .ex_valid_i(exv), .ex_is_branch_i(exb),
        .ex_taken_i(ext), .ex_target_i(extg),
        .prediction_result_o(res_o), .predicted_pc_o(ppc_o),
        .target_address_o(tgt_o), .is_branch_inst_o(isbr_o),
        .branch_flag_o(bf_o), .branch_address_o(baddr_o),
        .flush_o(flush_o), .busy_o(busy_o),
        .br_cnt_o(br_o), .miss_cnt_o(miss_o), .orphan_o(orph_o)
    );

    // Narrow-counter instance to reach saturation quickly.
    bp_resolve_unit #(.FLUSH_CYCLES(FC), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .stall_i(stall),
        .if_valid_i(ifv), .if_pc_i(ifpc),
        .if_pred_taken_i(ifpt), .if_pred_target_i(ifptg),
        .ex_valid_i(exv), .ex_is_branch_i(exb),
        .ex_taken_i(ext), .ex_target_i(extg),
        .prediction_result_o(s_res), .predicted_pc_o(s_ppc),
        .target_address_o(s_tgt), .is_branch_inst_o(s_isbr),
        .branch_flag_o(s_bf), .branch_address_o(s_baddr),
        .flush_o(s_flush), .busy_o(s_busy),
        .br_cnt_o(s_br), .miss_cnt_o(s_miss), .orphan_o(s_orph)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Behavioural model state
    logic        m_v = 1'b0, m_pt = 1'b0;
    logic [31:0] m_pc = '0, m_ptg = '0;
    int          m_fl = 0;
    logic        m_res = 1'b1, m_isbr = 1'b0, m_bf = 1'b0, m_orph = 1'b0;
    logic [31:0] m_ppc = '0, m_tgt = '0, m_baddr = '0;
    logic [31:0] m_br = '0, m_miss = '0;
    logic [2:0]  m_br3 = '0, m_miss3 = '0;

    task automatic model_step();
        logic had, mis;
        had = m_v;
        mis = 1'b0;
        if (!rst_n) begin
            m_v = 0; m_pt = 0; m_pc = 0; m_ptg = 0; m_fl = 0;
            m_res = 1; m_isbr = 0; m_bf = 0; m_orph = 0;
            m_ppc = 0; m_tgt = 0; m_baddr = 0;
            m_br = 0; m_miss = 0; m_br3 = 0; m_miss3 = 0;
            return;
        end
        m_res = 1; m_isbr = 0; m_bf = 0;
        if (m_fl > 0) begin
            if (!stall) m_fl = m_fl - 1;
        end else if (!stall) begin
            if (exv && had) begin
                if (exb) begin
                    if (m_pt != ext) mis = 1;
                    else if (m_pt && m_ptg != extg) mis = 1;
                end else begin
                    mis = m_pt;
                end
                m_res = !mis;
                m_isbr = exb;
                m_bf = exb && ext;
                m_baddr = extg;
                m_ppc = m_pc;
                m_tgt = m_ptg;
                if (exb && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (exb && m_br3 != 3'd7) m_br3 = m_br3 + 1;
                if (mis && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
                if (mis && m_miss3 != 3'd7) m_miss3 = m_miss3 + 1;
                m_v = 0;
            end else if (exv) begin
                m_orph = 1;
            end
            if (ifv) begin
                if (had && !exv) m_orph = 1;
                m_v = 1; m_pc = ifpc; m_pt = ifpt; m_ptg = ifptg;
            end
            if (mis) begin
                m_fl = FC;
                m_v = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stall = 0; ifv = 0; ifpt = 0; exv = 0; exb = 0; ext = 0;
        ifpc = 0; ifptg = 0; extg = 0;
    endtask

    task automatic check_model(input int c);
        string p;
        p = $sformatf("rnd%0d.", c);
        check({p, "res"}, res_o, m_res);
        check({p, "isbr"}, isbr_o, m_isbr);
        check({p, "bf"}, bf_o, m_bf);
        check({p, "ppc"}, ppc_o, m_ppc);
        check({p, "tgt"}, tgt_o, m_tgt);
        check({p, "baddr"}, baddr_o, m_baddr);
        check({p, "flush"}, flush_o, (m_fl > 0));
        check({p, "busy"}, busy_o, m_v);
        check({p, "orph"}, orph_o, m_orph);
        check({p, "br"}, br_o, m_br);
        check({p, "miss"}, miss_o, m_miss);
        check({p, "sbr"}, s_br, m_br3);
        check({p, "smiss"}, s_miss, m_miss3);
        check({p, "sflush"}, s_flush, (m_fl > 0));
    endtask

    // in_f = {stall, ifv, ifpt, exv, exb, ext}
    // ex_f = {res, isbr, bf, flush, busy, orph}
    typedef struct {
        logic [5:0]  in_f;
        logic [31:0] ifpc;
        logic [31:0] ifptg;
        logic [31:0] extg;
        logic [5:0]  ex_f;
        logic [31:0] e_ppc;
        logic [31:0] e_baddr;
        logic [7:0]  e_br;
        logic [7:0]  e_miss;
    } vec_t;

    localparam int NV = 19;
    vec_t tv[NV];

    initial begin
        tv[0]  = '{6'b010000, 32'h1023C, 32'h0, 32'h0,
                   6'b100010, 32'h0, 32'h0, 8'd0, 8'd0};
        tv[1]  = '{6'b011100, 32'h10240, 32'h10300, 32'h0,
                   6'b100010, 32'h1023C, 32'h0, 8'd0, 8'd0};
        tv[2]  = '{6'b000111, 32'h0, 32'h0, 32'h10300,
                   6'b111000, 32'h10240, 32'h10300, 8'd1, 8'd0};
        tv[3]  = '{6'b011000, 32'h10240, 32'h10300, 32'h0,
                   6'b100010, 32'h10240, 32'h10300, 8'd1, 8'd0};
        tv[4]  = '{6'b010110, 32'h10244, 32'h0, 32'h10244,
                   6'b010100, 32'h10240, 32'h10244, 8'd2, 8'd1};
        tv[5]  = '{6'b010111, 32'h10300, 32'h0, 32'h10300,
                   6'b100100, 32'h10240, 32'h10244, 8'd2, 8'd1};
        tv[6]  = '{6'b010000, 32'h10300, 32'h0, 32'h0,
                   6'b100000, 32'h10240, 32'h10244, 8'd2, 8'd1};
        tv[7]  = '{6'b011000, 32'h10248, 32'h10300, 32'h0,
                   6'b100010, 32'h10240, 32'h10244, 8'd2, 8'd1};
        tv[8]  = '{6'b000111, 32'h0, 32'h0, 32'h10400,
                   6'b011100, 32'h10248, 32'h10400, 8'd3, 8'd2};
        tv[9]  = '{6'b000000, 32'h0, 32'h0, 32'h0,
                   6'b100100, 32'h10248, 32'h10400, 8'd3, 8'd2};
        tv[10] = '{6'b000000, 32'h0, 32'h0, 32'h0,
                   6'b100000, 32'h10248, 32'h10400, 8'd3, 8'd2};
        tv[11] = '{6'b011000, 32'h1024C, 32'h10500, 32'h0,
                   6'b100010, 32'h10248, 32'h10400, 8'd3, 8'd2};
        tv[12] = '{6'b000100, 32'h0, 32'h0, 32'h0,
                   6'b000100, 32'h1024C, 32'h0, 8'd3, 8'd3};
        tv[13] = '{6'b100000, 32'h0, 32'h0, 32'h0,
                   6'b100100, 32'h1024C, 32'h0, 8'd3, 8'd3};
        tv[14] = '{6'b100000, 32'h0, 32'h0, 32'h0,
                   6'b100100, 32'h1024C, 32'h0, 8'd3, 8'd3};
        tv[15] = '{6'b100000, 32'h0, 32'h0, 32'h0,
                   6'b100100, 32'h1024C, 32'h0, 8'd3, 8'd3};
        tv[16] = '{6'b000000, 32'h0, 32'h0, 32'h0,
                   6'b100100, 32'h1024C, 32'h0, 8'd3, 8'd3};
        tv[17] = '{6'b000000, 32'h0, 32'h0, 32'h0,
                   6'b100000, 32'h1024C, 32'h0, 8'd3, 8'd3};
        tv[18] = '{6'b000111, 32'h0, 32'h0, 32'h999,
                   6'b100001, 32'h1024C, 32'h0, 8'd3, 8'd3};

        idle_in();
        rst_n = 0;
        tick();
        tick();
        check("rst.res", res_o, 1);
        check("rst.isbr", isbr_o, 0);
        check("rst.bf", bf_o, 0);
        check("rst.flush", flush_o, 0);
        check("rst.busy", busy_o, 0);
        check("rst.orph", orph_o, 0);
        check("rst.ppc", ppc_o, 0);
        check("rst.tgt", tgt_o, 0);
        check("rst.baddr", baddr_o, 0);
        check("rst.br", br_o, 0);
        check("rst.miss", miss_o, 0);
        check("rst.smiss", s_miss, 0);
        rst_n = 1;

        for (int i = 0; i < NV; i++) begin
            {stall, ifv, ifpt, exv, exb, ext} = tv[i].in_f;
            ifpc = tv[i].ifpc;
            ifptg = tv[i].ifptg;
            extg = tv[i].extg;
            tick();
            check($sformatf("v%0d.res", i), res_o, tv[i].ex_f[5]);
            check($sformatf("v%0d.isbr", i), isbr_o, tv[i].ex_f[4]);
            check($sformatf("v%0d.bf", i), bf_o, tv[i].ex_f[3]);
            check($sformatf("v%0d.flush", i), flush_o, tv[i].ex_f[2]);
            check($sformatf("v%0d.busy", i), busy_o, tv[i].ex_f[1]);
            check($sformatf("v%0d.orph", i), orph_o, tv[i].ex_f[0]);
            check($sformatf("v%0d.ppc", i), ppc_o, tv[i].e_ppc);
            check($sformatf("v%0d.baddr", i), baddr_o, tv[i].e_baddr);
            check($sformatf("v%0d.br", i), br_o, 32'(tv[i].e_br));
            check($sformatf("v%0d.miss", i), miss_o, 32'(tv[i].e_miss));
        end
        idle_in();

        // Six more mispredicts: narrow miss counter pins at 7.
        for (int k = 0; k < 6; k++) begin
            ifv = 1; ifpt = 1; ifpc = 32'h2000 + 32'(k * 4);
            ifptg = 32'h3000;
            tick();
            idle_in();
            exv = 1;
            tick();
            idle_in();
            tick();
            tick();
        end
        check("sat.miss", miss_o, 9);
        check("sat.smiss", s_miss, 3'd7);
        check("sat.sbr", s_br, 3'd3);
        check("sat.flush", flush_o, 0);

        // Reset while flushing.
        ifv = 1; ifpt = 1; ifpc = 32'h4000; ifptg = 32'h5000;
        tick();
        idle_in();
        exv = 1; exb = 1; ext = 0;
        tick();
        idle_in();
        check("mid.flush", flush_o, 1);
        check("mid.res", res_o, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        check("rstfl.flush", flush_o, 0);
        check("rstfl.res", res_o, 1);
        check("rstfl.miss", miss_o, 0);
        check("rstfl.orph", orph_o, 0);
        check("rstfl.ppc", ppc_o, 0);

        // Resolution with nothing captured.
        exv = 1; exb = 1; ext = 1; extg = 32'h7777;
        tick();
        idle_in();
        check("orph.orph", orph_o, 1);
        check("orph.res", res_o, 1);
        check("orph.isbr", isbr_o, 0);
        check("orph.baddr", baddr_o, 0);
        check("orph.busy", busy_o, 0);

        // Randomized traffic vs model.
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 5) == 0);
            ifv = 1'($urandom_range(0, 1));
            ifpt = 1'($urandom_range(0, 1));
            ifpc = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            ifptg = $urandom_range(0, 1) ? 32'h2000 : 32'h3000;
            exv = 1'($urandom_range(0, 1));
            exb = ($urandom_range(0, 3) != 0);
            ext = 1'($urandom_range(0, 1));
            extg = $urandom_range(0, 1) ? 32'h2000 : 32'h3000;
            tick();
            check_model(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
